// File: rtl/memwb_stage_if.sv
// Data-cache request/response bundle between the MEM stage and the D-cache.
// The stage is master (drives requests), the cache is slave.
interface memwb_stage_if #(
  parameter int WORD_W = 32
);
  logic              dmemREN;
  logic              dmemWEN;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic              dhit;
  logic [WORD_W-1:0] dmemload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );
endinterface

// File: rtl/memwb_stage.sv
// MEM stage: drives D-cache requests, stalls until dhit, loads MEM/WB.
// Owns sticky halt and the dhit wait watchdog.
module memwb_stage #(
  parameter int WORD_W   = 32,
  parameter int REG_W    = 5,
  parameter int WAIT_MAX = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              em_valid,
  input  logic [WORD_W-1:0] em_aluout,
  input  logic [WORD_W-1:0] em_rdat2,
  input  logic [WORD_W-1:0] em_extout,
  input  logic [WORD_W-1:0] em_npc,
  input  logic [REG_W-1:0]  em_wsel,
  input  logic              em_RegW,
  input  logic              em_DRen,
  input  logic              em_DWen,
  input  logic [1:0]        em_Mem,
  input  logic              em_halt,
  input  logic              wb_en,
  input  logic              flush,
  memwb_stage_if.master     dmem,
  output logic              mem_stall,
  output logic              wb_valid,
  output logic              wb_RegW,
  output logic [REG_W-1:0]  wb_wsel,
  output logic [WORD_W-1:0] wb_wdat,
  output logic              halt,
  output logic              mem_err
);
  localparam int CW = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              drop_q, drop_d;
  logic              halt_q, halt_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic              regw_q, regw_d;
  logic [REG_W-1:0]  wsel_q, wsel_d;
  logic [WORD_W-1:0] wdat_q, wdat_d;

  logic              memop;
  logic              busy;
  logic              ld;
  logic              keep;
  logic [WORD_W-1:0] ldat;
  logic [WORD_W-1:0] mux;

  assign memop = em_valid & (em_DRen | em_DWen) & ~halt_q;
  assign busy  = memop & (state_q != DONE);

  assign dmem.dmemREN   = busy & em_DRen;
  assign dmem.dmemWEN   = busy & em_DWen;
  assign dmem.dmemaddr  = em_aluout;
  assign dmem.dmemstore = em_rdat2;
  assign mem_stall      = busy & ~dmem.dhit;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ld      = 1'b0;
    unique case (state_q)
      IDLE, WAIT: begin
        if (memop) begin
          if (!dmem.dhit) begin
            state_d = WAIT;
          end else if (wb_en) begin
            ld      = 1'b1;
            state_d = IDLE;
          end else begin
            hold_d  = dmem.dmemload;
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
          ld      = wb_en & (state_q == IDLE);
        end
      end
      DONE: begin
        if (wb_en) begin
          ld      = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ldat = (state_q == DONE) ? hold_q : dmem.dmemload;
  // an access flushed while in flight still completes, but as a bubble
  assign keep = em_valid & ~drop_q;

  always_comb begin
    mux = em_aluout;
    unique case (em_Mem)
      2'b00: mux = em_aluout;
      2'b01: mux = ldat;
      2'b10: mux = em_npc;
      2'b11: mux = em_extout;
      default: mux = em_aluout;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    regw_d  = regw_q;
    wsel_d  = wsel_q;
    wdat_d  = wdat_q;
    if (ld) begin
      valid_d = keep;
      regw_d  = keep & em_RegW;
      wsel_d  = em_wsel;
      wdat_d  = mux;
    end
    if (flush) begin
      valid_d = 1'b0;
      regw_d  = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d == IDLE)
      cnt_d = '0;
    else if (state_q == WAIT && cnt_q != CW'(WAIT_MAX))
      cnt_d = cnt_q + CW'(1);
  end

  assign err_d  = err_q | (cnt_d == CW'(WAIT_MAX));
  assign drop_d = (state_d == IDLE) ? 1'b0 : (drop_q | flush);
  assign halt_d = halt_q | (ld & keep & em_halt & ~flush);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      drop_q  <= 1'b0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      regw_q  <= 1'b0;
      wsel_q  <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      drop_q  <= drop_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      regw_q  <= regw_d;
      wsel_q  <= wsel_d;
      wdat_q  <= wdat_d;
    end
  end

  assign wb_valid = valid_q;
  assign wb_RegW  = regw_q;
  assign wb_wsel  = wsel_q;
  assign wb_wdat  = wdat_q;
  assign halt     = halt_q;
  assign mem_err  = err_q;
endmodule

// File: tb/tb_memwb_stage.sv
// Randomized directed bench for memwb_stage.
// Expected writeback/request counts come from a transaction-level model.
module tb_memwb_stage;
  logic        CLK = 0;
  logic        RST;
  logic        em_valid;
  logic [31:0] em_aluout, em_rdat2, em_extout, em_npc;
  logic [4:0]  em_wsel;
  logic        em_RegW, em_DRen, em_DWen, em_halt;
  logic [1:0]  em_Mem;
  logic        wb_en, flush;
  logic        mem_stall, wb_valid, wb_RegW, halt, mem_err;
  logic [4:0]  wb_wsel;
  logic [31:0] wb_wdat;

  memwb_stage_if #(.WORD_W(32)) dm ();

  memwb_stage dut (
    .CLK(CLK), .RST(RST), .em_valid(em_valid),
    .em_aluout(em_aluout), .em_rdat2(em_rdat2),
    .em_extout(em_extout), .em_npc(em_npc),
    .em_wsel(em_wsel), .em_RegW(em_RegW),
    .em_DRen(em_DRen), .em_DWen(em_DWen),
    .em_Mem(em_Mem), .em_halt(em_halt),
    .wb_en(wb_en), .flush(flush), .dmem(dm),
    .mem_stall(mem_stall), .wb_valid(wb_valid),
    .wb_RegW(wb_RegW), .wb_wsel(wb_wsel),
    .wb_wdat(wb_wdat), .halt(halt), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  logic        x_valid, x_regw;
  logic [4:0]  x_wsel;
  logic [31:0] x_wdat;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag);
    chk({tag, "_valid"}, 32'(wb_valid), 32'(x_valid));
    chk({tag, "_regw"}, 32'(wb_RegW), 32'(x_regw));
    chk({tag, "_wsel"}, 32'(wb_wsel), 32'(x_wsel));
    chk({tag, "_wdat"}, wb_wdat, x_wdat);
  endtask

  function automatic logic [31:0] wsrc(input logic [1:0] m,
      input logic [31:0] a, input logic [31:0] l,
      input logic [31:0] n, input logic [31:0] e);
    case (m)
      2'b00: return a;
      2'b01: return l;
      2'b10: return n;
      default: return e;
    endcase
  endfunction

  task automatic edge_step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1; em_valid = 0; em_halt = 0;
    em_DRen = 0; em_DWen = 0; flush = 0;
    dm.dhit = 0; wb_en = 0;
    edge_step();
    RST = 0;
    x_valid = 0; x_regw = 0; x_wsel = 0; x_wdat = 0;
  endtask

  // kind: 0 alu, 1 load, 2 store
  task automatic mem_op(input int kind, input int lat, input int hold,
      input bit fl, input logic [31:0] alu, input logic [31:0] ldv,
      input logic [1:0] msel);
    int ren = 0, wen = 0, stl = 0;
    bit drop = 0;
    logic [31:0] exp;
    em_valid = 1; em_halt = 0;
    em_aluout = alu;
    em_rdat2 = $urandom; em_extout = $urandom; em_npc = $urandom;
    em_wsel = 5'($urandom_range(1, 31));
    em_RegW = (kind != 2);
    em_DRen = (kind == 1); em_DWen = (kind == 2);
    em_Mem = msel;
    flush = 0;
    exp = wsrc(msel, alu, ldv, em_npc, em_extout);
    if (kind == 0) begin
      dm.dhit = 0; wb_en = 1; dm.dmemload = $urandom;
      #1;
      chk("alu_stall", 32'(mem_stall), 0);
      chk("alu_req", 32'(dm.dmemREN | dm.dmemWEN), 0);
      edge_step();
    end else begin
      for (int c = 0; c <= lat; c++) begin
        dm.dhit = (c == lat);
        dm.dmemload = (c == lat) ? ldv : $urandom;
        wb_en = (c < lat) ? 1'($urandom_range(0, 1)) : (hold == 0);
        flush = fl && (c == 0) && (lat > 0);
        #1;
        if (c == 0) begin
          chk("addr", dm.dmemaddr, alu);
          chk("sdata", dm.dmemstore, em_rdat2);
        end
        ren += dm.dmemREN; wen += dm.dmemWEN; stl += mem_stall;
        edge_step();
        if (flush) begin
          drop = 1; x_valid = 0; x_regw = 0;
        end
        flush = 0;
        if (c < lat) chk_wb("stall_hold");
      end
      for (int h = 0; h < hold; h++) begin
        dm.dhit = 0; wb_en = 0; dm.dmemload = $urandom;
        #1;
        ren += dm.dmemREN; wen += dm.dmemWEN; stl += mem_stall;
        edge_step();
        chk_wb("done_hold");
      end
      if (hold > 0) begin
        wb_en = 1; dm.dmemload = $urandom;
        #1;
        ren += dm.dmemREN; wen += dm.dmemWEN; stl += mem_stall;
        edge_step();
      end
      chk("ren_cycles", ren, (kind == 1) ? lat + 1 : 0);
      chk("wen_cycles", wen, (kind == 2) ? lat + 1 : 0);
      chk("stall_cycles", stl, lat);
    end
    x_valid = !drop;
    x_regw = !drop && (kind != 2);
    x_wsel = em_wsel;
    x_wdat = exp;
    chk_wb("wb");
    em_valid = 0; em_DRen = 0; em_DWen = 0;
  endtask

  initial begin
    em_aluout = 0; em_rdat2 = 0; em_extout = 0; em_npc = 0;
    em_wsel = 0; em_RegW = 0; em_Mem = 0;
    dm.dmemload = 0;
    do_reset();
    #1;
    chk_wb("reset");
    chk("reset_halt", 32'(halt), 0);
    chk("reset_err", 32'(mem_err), 0);
    chk("reset_req", 32'(dm.dmemREN | dm.dmemWEN), 0);

    mem_op(0, 0, 0, 0, 32'h1234, 0, 2'b00);
    mem_op(1, 3, 0, 0, 32'h80, 32'hDEADBEEF, 2'b01);
    mem_op(2, 0, 2, 0, $urandom, 0, 2'b00);
    mem_op(1, 2, 0, 1, $urandom, $urandom, 2'b01);
    mem_op(1, 0, 1, 0, $urandom, $urandom, 2'b01);

    for (int t = 0; t < 30; t++) begin
      int k, m;
      k = $urandom_range(0, 2);
      m = (k == 1) ? 1 : $urandom_range(0, 3);
      if (k == 0 && m == 1) m = 2;
      mem_op(k, $urandom_range(0, 4), $urandom_range(0, 2),
             ($urandom_range(0, 3) == 0), $urandom, $urandom, 2'(m));
    end

    // halt instruction, then a store that must not request
    em_valid = 1; em_halt = 1; em_DRen = 0; em_DWen = 0;
    em_RegW = 0; em_Mem = 0; wb_en = 1; dm.dhit = 0;
    edge_step();
    chk("halt_set", 32'(halt), 1);
    em_halt = 0; em_DWen = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("halt_wen", 32'(dm.dmemWEN), 0);
      chk("halt_stall", 32'(mem_stall), 0);
      edge_step();
    end
    chk("halt_sticky", 32'(halt), 1);
    do_reset();
    chk("halt_rst", 32'(halt), 0);

    // watchdog
    mem_op(0, 0, 0, 0, 32'h55, 0, 2'b00);
    em_valid = 1; em_DRen = 1; em_RegW = 1; em_Mem = 1;
    wb_en = 1; dm.dhit = 0;
    for (int i = 0; i < 300; i++) begin
      edge_step();
      if (i == 100) chk("err_early", 32'(mem_err), 0);
    end
    chk("err_set", 32'(mem_err), 1);
    chk("err_stall", 32'(mem_stall), 1);
    chk("err_ren", 32'(dm.dmemREN), 1);
    chk("err_wbv", 32'(wb_valid), 1);
    do_reset();
    #1;
    chk("rst_err", 32'(mem_err), 0);
    chk("rst_halt", 32'(halt), 0);
    chk("rst_wbv", 32'(wb_valid), 0);
    chk("rst_ren", 32'(dm.dmemREN), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
